// File: rtl/load_store_unit.sv
// Byte-addressed RV32I load/store front end driving a single-port word memory with a 1-cycle registered read.
// Latency accept->resp_valid: error 1, SW 2, load 3, SB/SH 4 (read-modify-write).
// One request in flight; req_ready only in IDLE, response held stable until resp_ready.
module load_store_unit #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [31:0]              req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   input  logic [2:0]               req_funct3,
   input  logic                     req_store,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [DATA_WIDTH-1:0]    resp_rdata,
   output logic                     resp_err,
   output logic [ADDRESS_WIDTH-1:0] mem_a,
   output logic [DATA_WIDTH-1:0]    mem_wd,
   output logic                     mem_we,
   input  logic [DATA_WIDTH-1:0]    mem_rd
);

   typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;
   logic [1:0]               off_q, off_d;
   logic [2:0]               f3_q, f3_d;
   logic                     store_q, store_d;
   logic [15:0]              wdata_q, wdata_d;
   logic [ADDRESS_WIDTH-1:0] mem_a_q, mem_a_d;
   logic [DATA_WIDTH-1:0]    mem_wd_q, mem_wd_d;
   logic                     mem_we_q, mem_we_d;
   logic                     resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;
   logic                     resp_err_q, resp_err_d;

   logic                     accept;
   logic                     req_err;
   logic [7:0]               byte_sel;
   logic [15:0]              half_sel;
   logic [DATA_WIDTH-1:0]    load_val;
   logic [DATA_WIDTH-1:0]    merged;
   logic                     unused_addr_bits;

   // Address bits above the memory's reach are deliberately dropped.
   assign unused_addr_bits = ^req_addr[31:ADDRESS_WIDTH+2];

   assign req_ready  = (state_q == IDLE) & rst_n;
   assign accept     = req_valid & req_ready;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mem_a      = mem_a_q;
   assign mem_wd     = mem_wd_q;
   assign mem_we     = mem_we_q;

   // Classify the incoming request: unsupported funct3 or misaligned access.
   always_comb begin
      req_err = 1'b0;
      case (req_funct3)
         3'b000:         req_err = 1'b0;
         3'b001:         req_err = req_addr[0];
         3'b010:         req_err = |req_addr[1:0];
         3'b100:         req_err = req_store;
         3'b101:         req_err = req_store | req_addr[0];
         default:        req_err = 1'b1;
      endcase
   end

   // Pick the addressed lane from the read word and extend it for the load result.
   always_comb begin
      byte_sel = mem_rd[{off_q, 3'b000} +: 8];
      half_sel = off_q[1] ? mem_rd[31:16] : mem_rd[15:0];
      load_val = mem_rd;
      case (f3_q)
         3'b000:  load_val = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         3'b001:  load_val = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         default: load_val = mem_rd;
      endcase
   end

   // Merge sub-word store data into the addressed lane of the word just read.
   always_comb begin
      merged = mem_rd;
      if (f3_q[1:0] == 2'b00) begin
         merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end else if (off_q[1]) begin
         merged[31:16] = wdata_q;
      end else begin
         merged[15:0] = wdata_q;
      end
   end

   // Next-state and next-output logic of the request sequencer.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      off_d        = off_q;
      f3_d         = f3_q;
      store_d      = store_q;
      wdata_d      = wdata_q;
      mem_a_d      = mem_a_q;
      mem_wd_d     = mem_wd_q;
      mem_we_d     = 1'b0;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               idx_d        = req_addr[ADDRESS_WIDTH+1:2];
               off_d        = req_addr[1:0];
               f3_d         = req_funct3;
               store_d      = req_store;
               wdata_d      = req_wdata[15:0];
               resp_rdata_d = '0;
               resp_err_d   = 1'b0;
               if (req_err) begin
                  // Errors skip the memory entirely.
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_store && req_funct3 == 3'b010) begin
                  state_d  = WR;
                  mem_a_d  = req_addr[ADDRESS_WIDTH+1:2];
                  mem_wd_d = req_wdata;
                  mem_we_d = 1'b1;
               end else begin
                  state_d = RD;
                  mem_a_d = req_addr[ADDRESS_WIDTH+1:2];
               end
            end
         end
         RD: begin
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (store_q) begin
               mem_wd_d = merged;
               mem_we_d = 1'b1;
               state_d  = WR;
            end else begin
               resp_rdata_d = load_val;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end
         end
         WR: begin
            resp_valid_d = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset drops any pending write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         off_q        <= '0;
         f3_q         <= '0;
         store_q      <= 1'b0;
         wdata_q      <= '0;
         mem_a_q      <= '0;
         mem_wd_q     <= '0;
         mem_we_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         off_q        <= off_d;
         f3_q         <= f3_d;
         store_q      <= store_d;
         wdata_q      <= wdata_d;
         mem_a_q      <= mem_a_d;
         mem_wd_q     <= mem_wd_d;
         mem_we_q     <= mem_we_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural single-port memory.
// Latency is counted in cycles after the accept edge, sampled on falling edges.
// Response backpressure and mid-RMW reset are exercised explicitly.
module tb_load_store_unit;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic [2:0]    req_funct3;
   logic          req_store;
   logic          resp_valid;
   logic          resp_ready;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic [AW-1:0] mem_a;
   logic [31:0]   mem_wd;
   logic          mem_we;
   logic [31:0]   mem_rd;

   logic [31:0]   mem_model [0:(1<<AW)-1];
   int            we_total = 0;
   int            n_checks = 0;
   int            n_pass   = 0;
   int            n_fail   = 0;

   always #5 clk = ~clk;

   load_store_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .req_store  (req_store),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_we     (mem_we),
      .mem_rd     (mem_rd)
   );

   // Synchronous memory: write on WE, registered read-first data.
   always @(posedge clk) begin
      if (mem_we) mem_model[mem_a] <= mem_wd;
      mem_rd <= mem_model[mem_a];
   end

   // Count every cycle the write strobe is seen high.
   always @(negedge clk) begin
      if (mem_we) we_total++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_req_ready"},  req_ready,  0);
      check({tag, "_resp_valid"}, resp_valid, 0);
      check({tag, "_resp_rdata"}, resp_rdata, 0);
      check({tag, "_resp_err"},   resp_err,   0);
      check({tag, "_mem_we"},     mem_we,     0);
      check({tag, "_mem_a"},      mem_a,      0);
      check({tag, "_mem_wd"},     mem_wd,     0);
   endtask

   // Issue one request, measure latency, observe any write, then complete the handshake.
   task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                          input int exp_we_cyc, input logic [31:0] exp_wd);
      int            lat;
      int            we_n;
      int            we_cyc;
      logic [AW-1:0] we_a;
      logic [31:0]   we_d;
      logic [31:0]   exp_a;
      @(negedge clk);
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      resp_ready = (hold == 0);
      check({tag, "_req_ready"}, req_ready, 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 99; we_n = 0; we_cyc = -1; we_a = '0; we_d = '0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (mem_we) begin
            we_n++;
            we_cyc = c;
            we_a   = mem_a;
            we_d   = mem_wd;
         end
         if (resp_valid) begin
            lat = c;
            break;
         end
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_err"},     resp_err, exp_err);
      check({tag, "_rdata"},   resp_rdata, exp_rd);
      check({tag, "_we_count"}, we_n, (exp_we_cyc < 0) ? 0 : 1);
      if (exp_we_cyc >= 0) begin
         exp_a = {16'h0, addr[17:2]};
         check({tag, "_we_cycle"}, we_cyc, exp_we_cyc);
         check({tag, "_we_addr"},  we_a, exp_a);
         check({tag, "_we_data"},  we_d, exp_wd);
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, resp_valid, 1);
         check({tag, "_hold_rdata"}, resp_rdata, exp_rd);
         check({tag, "_hold_ready"}, req_ready, 0);
      end
      resp_ready = 1'b1;
   endtask

   initial begin
      int we0;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_funct3 = '0;
      req_store  = 1'b0;
      resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;

      // Word store
      run_req("sw",  1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 2, 1, 32'hDEADBEEF);
      // Loads of word 4 = DEADBEEF
      run_req("lb",  0, 3'b000, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 0, 3, -1, 32'h0);
      run_req("lbu", 0, 3'b100, 32'h13, 32'h0, 0, 32'h000000DE, 0, 3, -1, 32'h0);
      run_req("lh",  0, 3'b001, 32'h12, 32'h0, 0, 32'hFFFFDEAD, 0, 3, -1, 32'h0);
      run_req("lhu", 0, 3'b101, 32'h10, 32'h0, 0, 32'h0000BEEF, 0, 3, -1, 32'h0);
      run_req("lw",  0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0, 3, -1, 32'h0);
      // Sub-word read-modify-write
      run_req("sb",  1, 3'b000, 32'h11, 32'h00000055, 0, 32'h0, 0, 4, 3, 32'hDEAD55EF);
      run_req("sh",  1, 3'b001, 32'h12, 32'h00001234, 0, 32'h0, 0, 4, 3, 32'h123455EF);
      run_req("lw2", 0, 3'b010, 32'h10, 32'h0, 0, 32'h123455EF, 0, 3, -1, 32'h0);
      // Error responses never touch memory
      run_req("lw_mis", 0, 3'b010, 32'h12, 32'h0, 0, 32'h0, 1, 1, -1, 32'h0);
      run_req("sh_mis", 1, 3'b001, 32'h11, 32'hFFFF, 0, 32'h0, 1, 1, -1, 32'h0);
      run_req("f3_011", 0, 3'b011, 32'h10, 32'h0, 0, 32'h0, 1, 1, -1, 32'h0);
      run_req("sbu_bad", 1, 3'b100, 32'h10, 32'h0, 0, 32'h0, 1, 1, -1, 32'h0);
      check("mem4_after_err", mem_model[4], 32'h123455EF);
      // Response backpressure then a back-to-back request
      run_req("lb_hold", 0, 3'b000, 32'h10, 32'h0, 5, 32'hFFFFFFEF, 0, 3, -1, 32'h0);
      run_req("lbu_b2b", 0, 3'b100, 32'h11, 32'h0, 0, 32'h00000055, 0, 3, -1, 32'h0);
      // Reset during RD_WAIT of a byte store
      @(negedge clk);
      req_valid  = 1'b1;
      req_store  = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h10;
      req_wdata  = 32'hAA;
      check("sb_rst_req_ready", req_ready, 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      we0 = we_total;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset("midrst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("midrst_no_write", we_total, we0);
      check("midrst_mem4", mem_model[4], 32'h123455EF);
      run_req("lw_post", 0, 3'b010, 32'h10, 32'h0, 0, 32'h123455EF, 0, 3, -1, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Absolute guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
